// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/compare/logic, serial one-bit-per-cycle shifts,
// valid/ready handshake on operand and result sides.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready=1
//   SHIFT | serial shift in progress, one bit per cycle
//   DONE  | result/zero presented, waiting for out_ready
module alu_exec #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);
   localparam int SW = $clog2(XLEN);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] SK_SLL = 2'd0;
   localparam logic [1:0] SK_SRL = 2'd1;
   localparam logic [1:0] SK_SRA = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic [XLEN-1:0] shreg_q, shreg_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sk_q, sk_d;

   logic [SW-1:0]   shamt;
   logic            is_shift;
   logic [1:0]      sk_in;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] sh_next;

   assign shamt = op_b[SW-1:0];

   always_comb begin
      alu_res  = '0;
      is_shift = 1'b0;
      sk_in    = SK_SLL;
      case (alu_ctrl)
         4'b0000: alu_res = op_a + op_b;
         4'b1000: alu_res = op_a - op_b;
         4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         4'b0100: alu_res = op_a ^ op_b;
         4'b0110: alu_res = op_a | op_b;
         4'b0111: alu_res = op_a & op_b;
         // a zero-length shift finishes immediately with op_a
         4'b0001: begin is_shift = 1'b1; sk_in = SK_SLL; alu_res = op_a; end
         4'b0101: begin is_shift = 1'b1; sk_in = SK_SRL; alu_res = op_a; end
         4'b1101: begin is_shift = 1'b1; sk_in = SK_SRA; alu_res = op_a; end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (sk_q)
         SK_SRL:  sh_next = {1'b0, shreg_q[XLEN-1:1]};
         SK_SRA:  sh_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
         default: sh_next = {shreg_q[XLEN-2:0], 1'b0};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      sk_d     = sk_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (is_shift && (shamt != '0)) begin
                  state_d = SHIFT;
                  shreg_d = op_a;
                  cnt_d   = shamt;
                  sk_d    = sk_in;
               end else begin
                  state_d  = DONE;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
               end
            end
         end
         SHIFT: begin
            shreg_d = sh_next;
            cnt_d   = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
               state_d  = DONE;
               result_d = sh_next;
               zero_d   = (sh_next == '0);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         shreg_q  <= '0;
         cnt_q    <= '0;
         sk_q     <= SK_SLL;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         sk_q     <= sk_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign zero      = zero_q;
endmodule
